stopwatch_digits: RTL and testbench
===================================

# stopwatch_digits

Six-digit MM:SS.hh stopwatch that generates the digit codes driving the six-digit seven-segment display controller. It sits directly upstream of `sevenseg_control`, feeding its `d0`–`d5` inputs, and takes single-cycle debounced button pulses from the board input stage. All counting is BCD, so each output digit maps one-to-one onto a display position with no binary-to-BCD conversion.

## Interface

**Parameters**
- `TICK_DIV`, default 1_000_000: clk cycles per hundredth-second tick (100 MHz / 100 Hz). Benches set it to 4.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `start_stop` in 1: single-cycle pulse; toggles between running and paused.
- `clear` in 1: single-cycle pulse; zeroes the time.
- `lap` in 1: single-cycle pulse; freezes or unfreezes the display (see Configuration).
- `d0`–`d5` out 7 each: digit codes, with `d0` the rightmost digit.
- `running` out 1: high while counting.
- `rollover` out 1: one-cycle pulse on wrap from 59:59.99.

## Operation

**Digit code format** (consumed by `seven_seg_n`)
- bits [3:0]: BCD value.
- bit 4: decimal point on.
- bit 5: blank.
- bit 6: reserved, always 0.

**Digit mapping**
- `d0`: hundredths, 0–9.
- `d1`: tenths, 0–9.
- `d2`: seconds ones, 0–9, DP set.
- `d3`: seconds tens, 0–5.
- `d4`: minutes ones, 0–9, DP set.
- `d5`: minutes tens, 0–5.

**FSM states**
- IDLE: time is zero and not counting.
  - `start_stop` → RUN.
- RUN: counting.
  - `start_stop` → PAUSE.
  - `clear` → IDLE with time zeroed.
- PAUSE: counting halted, time held.
  - `start_stop` → RUN.
  - `clear` → IDLE.

**Event priority**
- `clear` wins over `start_stop` and `lap` in the same cycle.
- `clear` in IDLE is a no-op.

**Prescaler**
- Counts 0..TICK_DIV-1 only in RUN.
- Emits the internal tick when the count equals TICK_DIV-1, then returns to 0.
- Holds its value in PAUSE, so the sub-tick fraction is preserved.
- Zeroed on `clear` or `rst`.

**BCD cascade**
- Each digit increments when all lower digits are at their maximum on a tick.
- Wrap limits: 9→0, or 5→0 for the tens digits.
- At 59:59.99, a tick produces 00:00.00, pulses `rollover`, and stays in RUN.

**Reset values**
- State IDLE.
- All digits 0.
- `d2` = `d4` = 7'h10 (DP set); all other `d*` = 7'h00.
- `running` = 0, `rollover` = 0, lap freeze off.

## Timing

- All outputs are registered.
- Digits update on the clk edge after the tick cycle, one cycle of latency.
- `running` changes on the edge after the `start_stop` pulse.
- The first tick after entering RUN from IDLE occurs TICK_DIV cycles later.
- `rollover` is high for exactly the cycle in which the digits show 00:00.00 after the wrap.
- `rst` asserted mid-count takes effect at the next edge, regardless of state or prescaler value.
- Button pulses longer than one cycle are a caller error; each high cycle counts as one event.

## Configuration

- Macro: `STOPWATCH_LAP_EN`.

**Defined**
- `lap` in RUN toggles the freeze flag.
- While frozen, `d0`–`d5` hold the snapshot taken at the `lap` pulse; counting continues internally.
- A second `lap` releases the freeze; the display shows the live time from the next edge.
- `lap` in PAUSE or IDLE releases the freeze if it is set, otherwise it is ignored.
- `clear` releases the freeze.
- `rollover` still pulses while frozen.

**Undefined**
- The `lap` port remains present but is ignored.
- No snapshot registers are built.
- Outputs always show the live time.

## Structure

**Package `stopwatch_pkg`**
- Digit-code typedef with fields `rsvd`, `blank`, `dp`, `val[3:0]`.
- FSM state enum: IDLE, RUN, PAUSE.
- Constants `DIGIT_BLANK` = 7'h20 and `DP_BIT` = 4.
- Per-digit wrap limits.

**Sub-module `bcd_digit`**
- One 4-bit BCD counter parameterised by `MAX`.
- Ports: `clk`, `rst`, `clr`, `enb`, `q`, `carry`.
- `carry` = `enb` && (`q` == `MAX`).
- Instantiated six times and chained carry to `enb`.

## Test plan

Run with TICK_DIV = 4.

1. `rst` held 2 cycles → all digits 0, `d2`/`d4` = 7'h10, `running` = 0, `rollover` = 0.
2. `start_stop`, then 40 cycles → `running` = 1, `d0` = 0, `d1` = 1 (0.10 s); `start_stop` again → value holds for 20 cycles; `start_stop` again → count resumes with no lost fraction.
3. Force digits to 59:59.99 in RUN, advance one tick → all digits show 0, `rollover` high for exactly 1 cycle, `running` = 1.
4. `clear` and `start_stop` in the same cycle while in RUN → IDLE, all digits 0, `running` = 0.
5. With `STOPWATCH_LAP_EN`: `lap` at 00:00.05 → display holds 05 while 40 more cycles elapse; `lap` again → display shows 00:00.15.
6. Without the macro, repeat scenario 5 → `lap` is ignored and the display stays live.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared digit-code type, FSM states and wrap limits for the MM:SS.hh stopwatch
package stopwatch_pkg;
  typedef struct packed {
    logic       rsvd;
    logic       blank;
    logic       dp;
    logic [3:0] val;
  } digit_t;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [6:0] DIGIT_BLANK = 7'h20;
  localparam int DP_BIT = 4;
  localparam int NUM_DIGITS = 6;
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction
  function automatic digit_t mk_digit(input int idx, input logic [3:0] v);
    logic [6:0] c;
    c = {3'b000, v};
    c[DP_BIT] = (idx == 2 || idx == 4);
    return digit_t'(c);
  endfunction
endpackage

// File: rtl/stopwatch_digits_bcd_digit.sv
// bcd_digit: single BCD counter wrapping at MAX, with ripple carry for cascading
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       enb,
  output logic [3:0] q,
  output logic       carry
);
  assign carry = enb && (q == MAX);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (enb) q <= (q == MAX) ? 4'd0 : q + 4'd1;
  end
endmodule

// File: rtl/stopwatch_digits.sv
// stopwatch_digits: MM:SS.hh BCD stopwatch producing seven-segment digit codes.
// Optional lap freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_digits
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [6:0] d0,
  output logic [6:0] d1,
  output logic [6:0] d2,
  output logic [6:0] d3,
  output logic [6:0] d4,
  output logic [6:0] d5,
  output logic       running,
  output logic       rollover
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  state_t state, state_nx;
  logic [PW-1:0] pre;
  logic clr_ev, tick;
  logic [NUM_DIGITS-1:0] carry;
  logic [3:0] q [NUM_DIGITS];
  logic [3:0] shown [NUM_DIGITS];
  always_comb begin
    clr_ev = clear && state != IDLE;
    tick = state == RUN && pre == LAST;
    state_nx = clr_ev ? IDLE : start_stop ? (state == RUN ? PAUSE : RUN) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pre <= '0;
      rollover <= 1'b0;
    end else begin
      state <= state_nx;
      pre <= (clr_ev || tick) ? '0 : (state == RUN) ? pre + 1'b1 : pre;
      rollover <= carry[NUM_DIGITS-1] && !clr_ev;
    end
  end
  assign running = state == RUN;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit #(.MAX(digit_max(i))) u_dig (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr_ev),
      .enb  (i == 0 ? tick : carry[(i == 0) ? 0 : i-1]),
      .q    (q[i]),
      .carry(carry[i])
    );
  end
`ifdef STOPWATCH_LAP_EN
  logic frozen;
  logic [3:0] snap [NUM_DIGITS];
  // Freezing only starts from RUN; any other lap event just releases the hold.
  always_ff @(posedge clk) begin
    if (rst || clr_ev) frozen <= 1'b0;
    else if (lap) begin
      if (state == RUN && !frozen) begin
        frozen <= 1'b1;
        snap <= q;
      end else frozen <= 1'b0;
    end
  end
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) shown[k] = frozen ? snap[k] : q[k];
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) shown[k] = q[k];
  end
`endif
  assign d0 = mk_digit(0, shown[0]);
  assign d1 = mk_digit(1, shown[1]);
  assign d2 = mk_digit(2, shown[2]);
  assign d3 = mk_digit(3, shown[3]);
  assign d4 = mk_digit(4, shown[4]);
  assign d5 = mk_digit(5, shown[5]);
endmodule

// File: tb/tb_stopwatch_digits.sv
// tb_stopwatch_digits: directed plus random bench against a time-in-hundredths reference model
module tb_stopwatch_digits;
  localparam int TD = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [6:0] d0, d1, d2, d3, d4, d5;
  logic running, rollover;
  int compared = 0, mismatched = 0;
  int m_t = 0, m_pre = 0, m_st = 0, m_snap = 0;
  bit m_frozen = 1'b0, m_roll = 1'b0;

  always #5 clk = ~clk;

  stopwatch_digits #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .running(running), .rollover(rollover)
  );

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] code(input int t, input int k);
    int dv [6] = '{1, 10, 100, 1000, 6000, 60000};
    int md [6] = '{10, 10, 10, 6, 10, 6};
    return 7'((t / dv[k]) % md[k]) | ((k == 2 || k == 4) ? 7'h10 : 7'h00);
  endfunction

  // Reference: time as an integer count of hundredths; states 0=idle 1=run 2=pause.
  task automatic model(input bit r, input bit ss, input bit cl, input bit lp);
    int t0;
    bit tk, c;
    if (r) begin
      m_t = 0; m_pre = 0; m_st = 0; m_frozen = 0; m_roll = 0;
    end else begin
      t0 = m_t;
      tk = m_st == 1 && m_pre == TD - 1;
      c = cl && m_st != 0;
      if (c) begin
        m_t = 0; m_pre = 0; m_st = 0; m_frozen = 0; m_roll = 0;
      end else begin
        if (tk) m_t = (m_t + 1) % 360000;
        m_roll = tk && t0 == 359999;
        if (m_st == 1) m_pre = (m_pre + 1) % TD;
        if (LAP_EN && lp) begin
          if (m_st == 1 && !m_frozen) begin
            m_frozen = 1; m_snap = t0;
          end else m_frozen = 0;
        end
        if (ss) m_st = (m_st == 1) ? 2 : 1;
      end
    end
  endtask

  task automatic check_all();
    int s;
    s = m_frozen ? m_snap : m_t;
    chk("d0", d0, code(s, 0));
    chk("d1", d1, code(s, 1));
    chk("d2", d2, code(s, 2));
    chk("d3", d3, code(s, 3));
    chk("d4", d4, code(s, 4));
    chk("d5", d5, code(s, 5));
    chk("running", {6'b0, running}, {6'b0, m_st == 1});
    chk("rollover", {6'b0, rollover}, {6'b0, m_roll});
  endtask

  task automatic step(input bit ss = 0, input bit cl = 0, input bit lp = 0, input bit r = 0);
    rst = r; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    model(r, ss, cl, lp);
    #1;
    rst = 0; start_stop = 0; clear = 0; lap = 0;
    check_all();
  endtask

  initial begin
    bit seen;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_d0", d0, 7'h00);
    chk("rst_d2", d2, 7'h10);
    chk("rst_d4", d4, 7'h10);
    chk("rst_d5", d5, 7'h00);
    chk("rst_running", {6'b0, running}, 7'h00);
    chk("rst_rollover", {6'b0, rollover}, 7'h00);

    step(1);
    repeat (40) step();
    chk("run_running", {6'b0, running}, 7'h01);
    chk("run_d0", d0, 7'h00);
    chk("run_d1", d1, 7'h01);
    step(1);
    repeat (20) step();
    chk("pause_d1", d1, 7'h01);
    chk("pause_d0", d0, 7'h00);
    chk("pause_running", {6'b0, running}, 7'h00);
    step(1);
    step();
    step();
    chk("resume_early_d0", d0, 7'h00);
    step();
    chk("resume_d0", d0, 7'h01);

    force dut.g_dig[0].u_dig.q = 4'd9;
    force dut.g_dig[1].u_dig.q = 4'd9;
    force dut.g_dig[2].u_dig.q = 4'd9;
    force dut.g_dig[3].u_dig.q = 4'd5;
    force dut.g_dig[4].u_dig.q = 4'd9;
    force dut.g_dig[5].u_dig.q = 4'd5;
    #1;
    release dut.g_dig[0].u_dig.q;
    release dut.g_dig[1].u_dig.q;
    release dut.g_dig[2].u_dig.q;
    release dut.g_dig[3].u_dig.q;
    release dut.g_dig[4].u_dig.q;
    release dut.g_dig[5].u_dig.q;
    m_t = 359999;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      seen = rollover;
    end
    chk("wrap_seen", {6'b0, seen}, 7'h01);
    chk("wrap_d0", d0, 7'h00);
    chk("wrap_d2", d2, 7'h10);
    chk("wrap_d3", d3, 7'h00);
    chk("wrap_d5", d5, 7'h00);
    chk("wrap_running", {6'b0, running}, 7'h01);
    step();
    chk("wrap_pulse_end", {6'b0, rollover}, 7'h00);

    step(1, 1);
    chk("clr_running", {6'b0, running}, 7'h00);
    chk("clr_d0", d0, 7'h00);
    chk("clr_d4", d4, 7'h10);

    step(1);
    repeat (20) step();
    chk("lap_at_d0", d0, 7'h05);
    step(0, 0, 1);
    repeat (40) step();
    chk("lap_hold_d0", d0, 7'h05);
    chk("lap_hold_d1", d1, LAP_EN ? 7'h00 : 7'h01);
    step(0, 0, 1);
    chk("lap_rel_d0", d0, 7'h05);
    chk("lap_rel_d1", d1, 7'h01);

    for (int i = 0; i < 600; i++)
      step($urandom_range(7) == 0, $urandom_range(29) == 0,
           $urandom_range(9) == 0, $urandom_range(199) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
